// File: rtl/regfile_wr_demux_q.sv
// Register-file write-enable demux with a DEPTH-entry request FIFO.
// Drains one entry per unstalled cycle into a registered one-hot enable pulse and write data.
module regfile_wr_demux_q #(
   parameter int SEL_W         = 5,
   parameter int DATA_W        = 32,
   parameter int DEPTH         = 4,
   parameter int ZERO_SUPPRESS = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [SEL_W-1:0]             req_sel,
   input  logic [DATA_W-1:0]            req_data,
   input  logic                         stall,
   output logic [(2**SEL_W)-1:0]        we_out,
   output logic [DATA_W-1:0]            wdata_out,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int N_REG = 2**SEL_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [SEL_W-1:0]  sel_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic              push, pop;
   logic [SEL_W-1:0]  head_sel;
   logic [N_REG-1:0]  we_next;

   assign req_ready = (count != FULL_CNT);
   assign busy      = (count != '0);
   assign push      = req_valid && req_ready;
   assign pop       = !stall && busy;
   assign head_sel  = sel_mem[rd_ptr];

   always_comb begin
      we_next = '0;
      if (pop && !((ZERO_SUPPRESS != 0) && (head_sel == '0)))
         we_next[head_sel] = 1'b1;
   end

   // Storage is not reset: entries are only ever read behind a valid count.
   always_ff @(posedge clk) begin
      if (push) begin
         sel_mem[wr_ptr]  <= req_sel;
         data_mem[wr_ptr] <= req_data;
      end
   end

   // DEPTH is a power of two, so pointer wrap is the natural overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         we_out    <= '0;
         wdata_out <= '0;
      end else begin
         we_out <= we_next;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr    <= rd_ptr + 1'b1;
            wdata_out <= data_mem[rd_ptr];
         end
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

endmodule
